// File: rtl/agc_loop_ctrl.sv
// AGC gain-loop sequencer: steps the PWM gain generator through settle, estimate
// and update phases, picks coarse or fine steps, and tracks lock on estimate error.
module agc_loop_ctrl #(
  parameter int TO_W     = 12,
  parameter int SETTLE_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                agc_start,
  input  logic                agc_stop,
  input  logic                agc_hold,
  input  logic [SETTLE_W-1:0] settle_len,
  input  logic [3:0]          lock_num,
  input  logic [8:0]          coarse_th,
  input  logic [8:0]          pwr_req_val,
  input  logic [8:0]          pwr_est_dB,
  input  logic                pwr_est_end,
  input  logic                pwm_val_up,
  output logic                est_start,
  output logic                pwm_ena,
  output logic                pwm_th_ena,
  output logic [1:0]          pwm_step,
  output logic                agc_lock,
  output logic                est_err,
  output logic [2:0]          agc_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_INIT   = 3'd1,
    S_SETTLE = 3'd2,
    S_EST    = 3'd3,
    S_UPD    = 3'd4,
    S_HOLD   = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic [3:0]          lock_cnt_q, lock_cnt_d;
  logic [3:0]          unlock_cnt_q, unlock_cnt_d;
  logic                coarse_q, coarse_d;
  logic                agc_lock_q, agc_lock_d;
  logic [1:0]          pwm_step_q, pwm_step_d;
  logic                est_err_q, est_err_d;
  logic                est_start_q, est_start_d;
  logic                pwm_ena_q, pwm_ena_d;
  logic                pwm_th_ena_q, pwm_th_ena_d;

  logic [8:0] abs_d_s;
  logic       in_range_s;
  logic       far_s;
  logic [3:0] lock_req_s;

  // |req - est| from the 10-bit two's-complement difference
  function automatic logic [8:0] abs_delta(input logic [8:0] req, input logic [8:0] est);
    logic [9:0] diff;
    logic [9:0] mag;
    diff = {1'b0, req} - {1'b0, est};
    if (diff[9]) begin
      mag = ~diff + 10'd1;
    end else begin
      mag = diff;
    end
    return mag[8:0];
  endfunction

  // Estimate classification against the lock window and the coarse threshold
  always_comb begin
    abs_d_s    = abs_delta(pwr_req_val, pwr_est_dB);
    in_range_s = (abs_d_s <= 9'd5);
    far_s      = (abs_d_s > coarse_th);
    if (lock_num == 4'd0) begin
      lock_req_s = 4'd1;
    end else begin
      lock_req_s = lock_num;
    end
  end

  // Next-state, counter and lock/step bookkeeping
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    to_cnt_d     = to_cnt_q;
    lock_cnt_d   = lock_cnt_q;
    unlock_cnt_d = unlock_cnt_q;
    coarse_d     = coarse_q;
    agc_lock_d   = agc_lock_q;
    pwm_step_d   = pwm_step_q;
    est_err_d    = 1'b0;
    if (agc_stop) begin
      state_d    = S_IDLE;
      agc_lock_d = 1'b0;
    end else if (agc_start) begin
      // INIT is entered with the loop already cleared back to coarse acquisition
      state_d      = S_INIT;
      lock_cnt_d   = 4'd0;
      unlock_cnt_d = 4'd0;
      agc_lock_d   = 1'b0;
      coarse_d     = 1'b1;
      pwm_step_d   = 2'd3;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_IDLE;
        end
        S_INIT: begin
          state_d      = S_SETTLE;
          settle_cnt_d = settle_len;
        end
        S_SETTLE: begin
          if (settle_cnt_q == {SETTLE_W{1'b0}}) begin
            if (agc_hold) begin
              state_d = S_HOLD;
            end else begin
              state_d  = S_EST;
              to_cnt_d = {TO_W{1'b0}};
            end
          end else begin
            settle_cnt_d = settle_cnt_q - SETTLE_W'(1);
          end
        end
        S_HOLD: begin
          if (agc_hold) begin
            state_d = S_HOLD;
          end else begin
            state_d  = S_EST;
            to_cnt_d = {TO_W{1'b0}};
          end
        end
        S_EST: begin
          if (pwr_est_end) begin
            state_d = S_UPD;
            if (in_range_s) begin
              lock_cnt_d = (lock_cnt_q == 4'd15) ? 4'd15 : lock_cnt_q + 4'd1;
            end else begin
              lock_cnt_d = 4'd0;
            end
            if (lock_cnt_d >= lock_req_s) begin
              agc_lock_d = 1'b1;
            end else begin
              agc_lock_d = agc_lock_q;
            end
            if (agc_lock_q && far_s) begin
              unlock_cnt_d = (unlock_cnt_q == 4'd15) ? 4'd15 : unlock_cnt_q + 4'd1;
            end else begin
              unlock_cnt_d = 4'd0;
            end
            // Sustained error while locked drops back to coarse acquisition
            if (agc_lock_q && (unlock_cnt_d >= lock_req_s)) begin
              agc_lock_d   = 1'b0;
              lock_cnt_d   = 4'd0;
              unlock_cnt_d = 4'd0;
              coarse_d     = 1'b1;
            end else if (!far_s) begin
              coarse_d = 1'b0;
            end else begin
              coarse_d = coarse_q;
            end
          end else if (&to_cnt_q) begin
            est_err_d    = 1'b1;
            state_d      = S_SETTLE;
            settle_cnt_d = settle_len;
          end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
          end
        end
        S_UPD: begin
          if (pwm_val_up) begin
            state_d      = S_SETTLE;
            settle_cnt_d = settle_len;
            pwm_step_d   = coarse_q ? 2'd3 : 2'd1;
          end else begin
            state_d = S_UPD;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Output strobes derived from the upcoming state so they register cleanly
  always_comb begin
    est_start_d  = (state_d == S_EST) && (state_q != S_EST);
    pwm_ena_d    = (state_d != S_IDLE);
    pwm_th_ena_d = (state_d == S_INIT);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      settle_cnt_q <= {SETTLE_W{1'b0}};
      to_cnt_q     <= {TO_W{1'b0}};
      lock_cnt_q   <= 4'd0;
      unlock_cnt_q <= 4'd0;
      coarse_q     <= 1'b1;
      agc_lock_q   <= 1'b0;
      pwm_step_q   <= 2'd3;
      est_err_q    <= 1'b0;
      est_start_q  <= 1'b0;
      pwm_ena_q    <= 1'b0;
      pwm_th_ena_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      to_cnt_q     <= to_cnt_d;
      lock_cnt_q   <= lock_cnt_d;
      unlock_cnt_q <= unlock_cnt_d;
      coarse_q     <= coarse_d;
      agc_lock_q   <= agc_lock_d;
      pwm_step_q   <= pwm_step_d;
      est_err_q    <= est_err_d;
      est_start_q  <= est_start_d;
      pwm_ena_q    <= pwm_ena_d;
      pwm_th_ena_q <= pwm_th_ena_d;
    end
  end

  assign est_start  = est_start_q;
  assign pwm_ena    = pwm_ena_q;
  assign pwm_th_ena = pwm_th_ena_q;
  assign pwm_step   = pwm_step_q;
  assign agc_lock   = agc_lock_q;
  assign est_err    = est_err_q;
  assign agc_state  = state_q;

endmodule

// File: tb/tb_agc_loop_ctrl.sv
// Randomized bench for agc_loop_ctrl; expected lock/step/timing come from a
// transaction-level model of the loop rules kept in this file.
module tb_agc_loop_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       agc_start, agc_stop, agc_hold;
  logic [7:0] settle_len;
  logic [3:0] lock_num;
  logic [8:0] coarse_th, pwr_req_val, pwr_est_dB;
  logic       pwr_est_end, pwm_val_up;
  logic       est_start, pwm_ena, pwm_th_ena, agc_lock, est_err;
  logic [1:0] pwm_step;
  logic [2:0] agc_state;

  int checks = 0;
  int errors = 0;

  // Model: consecutive in-range / far run lengths, lock flag, coarse mode, step
  int m_run_in, m_run_far, m_lock, m_coarse, m_step;

  agc_loop_ctrl #(.TO_W(4), .SETTLE_W(8)) dut (
    .clk(clk), .reset(reset), .agc_start(agc_start), .agc_stop(agc_stop),
    .agc_hold(agc_hold), .settle_len(settle_len), .lock_num(lock_num),
    .coarse_th(coarse_th), .pwr_req_val(pwr_req_val), .pwr_est_dB(pwr_est_dB),
    .pwr_est_end(pwr_est_end), .pwm_val_up(pwm_val_up), .est_start(est_start),
    .pwm_ena(pwm_ena), .pwm_th_ena(pwm_th_ena), .pwm_step(pwm_step),
    .agc_lock(agc_lock), .est_err(est_err), .agc_state(agc_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset;
    m_run_in  = 0;
    m_run_far = 0;
    m_lock    = 0;
    m_coarse  = 1;
    m_step    = 3;
  endtask

  task automatic model_est(input int est);
    int  d, a, ln;
    bit  was_locked;
    d  = int'(pwr_req_val) - est;
    a  = (d < 0) ? -d : d;
    ln = (lock_num == 0) ? 1 : int'(lock_num);
    was_locked = (m_lock != 0);
    m_run_in  = (a <= 5) ? m_run_in + 1 : 0;
    if (m_run_in >= ln) m_lock = 1;
    m_run_far = (was_locked && a > int'(coarse_th)) ? m_run_far + 1 : 0;
    if (was_locked && m_run_far >= ln) begin
      m_lock = 0; m_run_in = 0; m_run_far = 0; m_coarse = 1;
    end else if (a <= int'(coarse_th)) begin
      m_coarse = 0;
    end
  endtask

  task automatic check_reset_vals;
    chk("rst_state", agc_state, 0);
    chk("rst_est_start", est_start, 0);
    chk("rst_pwm_ena", pwm_ena, 0);
    chk("rst_th_ena", pwm_th_ena, 0);
    chk("rst_est_err", est_err, 0);
    chk("rst_lock", agc_lock, 0);
    chk("rst_step", pwm_step, 3);
  endtask

  task automatic wait_est(input int exp);
    int n = 0;
    do begin
      tick;
      n++;
    end while (est_start !== 1'b1 && n < 400);
    chk("est_latency", n, exp);
    chk("est_state", agc_state, 3);
    chk("est_pwm_ena", pwm_ena, 1);
  endtask

  task automatic do_start;
    agc_start = 1'b1;
    tick;
    agc_start = 1'b0;
    model_reset();
    chk("init_state", agc_state, 1);
    chk("init_th_ena", pwm_th_ena, 1);
    wait_est(int'(settle_len) + 2);
    chk("init_step", pwm_step, 3);
  endtask

  task automatic estimate(input int est, input int ed);
    for (int i = 0; i < ed; i++) begin
      tick;
      chk("est_pulse_once", est_start, 0);
    end
    pwr_est_dB  = est[8:0];
    pwr_est_end = 1'b1;
    tick;
    pwr_est_end = 1'b0;
    model_est(est);
    chk("lock", agc_lock, m_lock);
    chk("upd_state", agc_state, 4);
    chk("step_kept", pwm_step, m_step);
  endtask

  task automatic update(input int ud);
    for (int i = 0; i < ud; i++) tick;
    pwm_val_up = 1'b1;
    tick;
    pwm_val_up = 1'b0;
    m_step = (m_coarse != 0) ? 3 : 1;
    chk("step", pwm_step, m_step);
    chk("settle_state", agc_state, 2);
  endtask

  task automatic iterate(input int est, input int ed, input int ud);
    estimate(est, ed);
    update(ud);
    wait_est(int'(settle_len) + 1);
  endtask

  initial begin
    int n;
    int est;
    reset = 1'b1; agc_start = 1'b0; agc_stop = 1'b0; agc_hold = 1'b0;
    settle_len = 8'd3; lock_num = 4'd2; coarse_th = 9'd40; pwr_req_val = 9'd200;
    pwr_est_dB = 9'd0; pwr_est_end = 1'b0; pwm_val_up = 1'b0;
    tick; tick;
    check_reset_vals();
    reset = 1'b0;
    tick;
    chk("idle_stays", agc_state, 0);

    // Acquisition, lock, then loss of lock on sustained error
    do_start();
    iterate(300, 1, 1);
    iterate(180, 1, 1);
    chk("fine_after_180", pwm_step, 1);
    iterate(198, 1, 1);
    iterate(201, 1, 1);
    chk("locked_after_201", agc_lock, 1);
    iterate(202, 1, 1);
    iterate(250, 1, 1);
    chk("still_locked", agc_lock, 1);
    estimate(250, 1);
    chk("unlocked", agc_lock, 0);
    update(1);
    chk("coarse_again", pwm_step, 3);

    // Hold at settle exit, then release
    agc_hold = 1'b1;
    for (int i = 0; i <= int'(settle_len); i++) begin
      tick;
      chk("hold_no_est", est_start, 0);
    end
    chk("hold_state", agc_state, 5);
    tick; tick; tick;
    chk("hold_stays", agc_state, 5);
    agc_hold = 1'b0;
    tick;
    chk("hold_rel_state", agc_state, 3);
    chk("hold_rel_est", est_start, 1);

    // Estimate timeout with no pwr_est_end
    n = 0;
    do begin
      tick;
      n++;
    end while (est_err !== 1'b1 && n < 100);
    chk("timeout_latency", n, 16);
    chk("timeout_state", agc_state, 2);
    chk("timeout_lock_kept", agc_lock, m_lock);
    wait_est(int'(settle_len) + 1);
    chk("est_err_pulse", est_err, 0);

    // Randomized rounds
    for (int r = 0; r < 3; r++) begin
      settle_len  = 8'($urandom_range(0, 6));
      lock_num    = 4'($urandom_range(0, 3));
      coarse_th   = 9'($urandom_range(0, 60));
      pwr_req_val = 9'($urandom_range(100, 400));
      do_start();
      for (int k = 0; k < 30; k++) begin
        if ($urandom_range(0, 2) != 0) begin
          est = int'(pwr_req_val) + int'($urandom_range(0, 16)) - 8;
        end else begin
          est = int'($urandom_range(0, 511));
        end
        iterate(est, int'($urandom_range(0, 5)), int'($urandom_range(0, 3)));
      end
    end

    // Stop and start together while locked in EST
    settle_len = 8'd2; lock_num = 4'd2; coarse_th = 9'd40; pwr_req_val = 9'd200;
    do_start();
    iterate(200, 1, 1);
    iterate(202, 0, 0);
    chk("pre_stop_lock", agc_lock, 1);
    agc_stop = 1'b1; agc_start = 1'b1;
    tick;
    agc_stop = 1'b0; agc_start = 1'b0;
    chk("stop_state", agc_state, 0);
    chk("stop_pwm_ena", pwm_ena, 0);
    chk("stop_lock", agc_lock, 0);

    // Restart from UPD
    do_start();
    estimate(199, 1);
    agc_start = 1'b1;
    tick;
    agc_start = 1'b0;
    chk("upd_restart_state", agc_state, 1);
    chk("upd_restart_th", pwm_th_ena, 1);
    tick;
    chk("th_ena_pulse", pwm_th_ena, 0);
    chk("restart_settle", agc_state, 2);
    model_reset();

    // Reset mid-UPD; a late pwm_val_up must not wake the loop
    wait_est(int'(settle_len) + 1);
    estimate(300, 0);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check_reset_vals();
    pwm_val_up = 1'b1;
    tick;
    pwm_val_up = 1'b0;
    chk("late_valup_state", agc_state, 0);
    chk("late_valup_ena", pwm_ena, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
